alu_regfile: RTL and testbench



---
 rtl/alu_regfile.sv | 70 +++++++
 tb/tb_alu_regfile.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_regfile.sv
// Execute-stage datapath: 32x32 register file (2 comb read, 1 clocked write) plus combinational ALU.
// Optional write-through forwarding on the read ports when ALU_REGFILE_BYPASS_EN is defined.
module alu_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  readReg1,
    input  logic [4:0]  readReg2,
    input  logic [4:0]  writeReg,
    input  logic [31:0] writeData,
    input  logic        regWrite,
    output logic [31:0] readData1,
    output logic [31:0] readData2,
    input  logic [31:0] aluA,
    input  logic [31:0] aluB,
    input  logic [2:0]  aluOp,
    input  logic [4:0]  shamt,
    output logic [31:0] aluOut,
    output logic        zeroFlag
);

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned REG_AW   = 5;
    localparam int unsigned NUM_REGS = 1 << REG_AW;

    logic [DATA_W-1:0] regs [NUM_REGS];

    // Register array; reset clears everything and overrides any concurrent write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (regWrite && (writeReg != '0)) begin
            regs[writeReg] <= writeData;
        end
    end

    // Read ports; r0 is forced to zero so it never depends on array contents.
    always_comb begin
        readData1 = (readReg1 == '0) ? '0 : regs[readReg1];
        readData2 = (readReg2 == '0) ? '0 : regs[readReg2];
`ifdef ALU_REGFILE_BYPASS_EN
        if (regWrite && !reset && (writeReg != '0) && (readReg1 == writeReg)) begin
            readData1 = writeData;
        end
        if (regWrite && !reset && (writeReg != '0) && (readReg2 == writeReg)) begin
            readData2 = writeData;
        end
`endif
    end

    // ALU operation select; arithmetic wraps, overflow is ignored.
    always_comb begin
        aluOut = '0;
        case (aluOp)
            3'd0:    aluOut = aluA + aluB;
            3'd1:    aluOut = aluA - aluB;
            3'd2:    aluOut = aluA & aluB;
            3'd3:    aluOut = aluA | aluB;
            3'd4:    aluOut = aluB << shamt;
            3'd5:    aluOut = aluB >> shamt;
            3'd6:    aluOut = ~(aluA | aluB);
            3'd7:    aluOut = DATA_W'(($signed(aluA) < $signed(aluB)) ? 1 : 0);
            default: aluOut = '0;
        endcase
    end

    assign zeroFlag = (aluOut == '0);

endmodule

// File: tb/tb_alu_regfile.sv
// Self-checking bench for alu_regfile: directed spec cases plus randomized traffic
// against an array-based register model and an arithmetic ALU model.
module tb_alu_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  readReg1, readReg2, writeReg;
    logic [31:0] writeData;
    logic        regWrite;
    logic [31:0] readData1, readData2;
    logic [31:0] aluA, aluB;
    logic [2:0]  aluOp;
    logic [4:0]  shamt;
    logic [31:0] aluOut;
    logic        zeroFlag;

    int nCompared   = 0;
    int nMismatched = 0;

    logic [31:0] mdl [32];

    always #5 clk = ~clk;

    alu_regfile dut (
        .clk(clk), .reset(reset),
        .readReg1(readReg1), .readReg2(readReg2),
        .writeReg(writeReg), .writeData(writeData), .regWrite(regWrite),
        .readData1(readData1), .readData2(readData2),
        .aluA(aluA), .aluB(aluB), .aluOp(aluOp), .shamt(shamt),
        .aluOut(aluOut), .zeroFlag(zeroFlag)
    );

    // Expected read value given the current (pre-edge) port inputs.
    function automatic logic [31:0] expRead(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
`ifdef ALU_REGFILE_BYPASS_EN
        if (regWrite && !reset && a == writeReg) return writeData;
`endif
        return mdl[a];
    endfunction

    // ALU reference computed with 64-bit integer arithmetic and powers of two.
    function automatic logic [31:0] expAlu(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [4:0] s);
        longint unsigned m = 64'h1_0000_0000;
        longint unsigned la = a;
        longint unsigned lb = b;
        longint unsigned p2 = 1;
        int ia = a;
        int ib = b;
        for (int k = 0; k < int'(s); k++) p2 = p2 * 2;
        case (op)
            3'd0: return 32'((la + lb) % m);
            3'd1: return 32'((la + m - lb) % m);
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return 32'((lb * p2) % m);
            3'd5: return 32'(lb / p2);
            3'd6: return 32'hFFFF_FFFF ^ (a | b);
            default: return (ia < ib) ? 32'd1 : 32'd0;
        endcase
    endfunction

    // Advance one edge and apply the architectural write rule to the model.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
        end else if (regWrite && writeReg != 5'd0) begin
            mdl[writeReg] = writeData;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; regWrite = 1'b1; writeReg = 5'd7; writeData = 32'hDEAD_BEEF;
        readReg1 = 5'd5; readReg2 = 5'd31;
        tick();
        nCompared++;
        if (readData1 !== 32'd0) begin
            nMismatched++; $display("FAIL reset_rd1: got %h want %h", readData1, 32'd0);
        end
        nCompared++;
        if (readData2 !== 32'd0) begin
            nMismatched++; $display("FAIL reset_rd2: got %h want %h", readData2, 32'd0);
        end
        reset = 1'b0; regWrite = 1'b0; readReg1 = 5'd7;
        #1;
        nCompared++;
        if (readData1 !== 32'd0) begin
            nMismatched++; $display("FAIL reset_wins_write: got %h want %h", readData1, 32'd0);
        end
    endtask

    task automatic test_write_read();
        regWrite = 1'b1; writeReg = 5'd3; writeData = 32'h0000_00AA;
        tick();
        regWrite = 1'b0; readReg1 = 5'd3;
        #1;
        nCompared++;
        if (readData1 !== 32'h0000_00AA) begin
            nMismatched++; $display("FAIL write_r3: got %h want %h", readData1, 32'hAA);
        end
        regWrite = 1'b1; writeReg = 5'd0; writeData = 32'hFFFF_FFFF;
        tick();
        regWrite = 1'b0; readReg1 = 5'd0; readReg2 = 5'd0;
        #1;
        nCompared++;
        if (readData1 !== 32'd0 || readData2 !== 32'd0) begin
            nMismatched++;
            $display("FAIL write_r0: got %h/%h want 0/0", readData1, readData2);
        end
    endtask

    task automatic test_alu_directed();
        logic [2:0]  ops [9] = '{3'd0, 3'd1, 3'd0, 3'd2, 3'd3, 3'd6, 3'd7, 3'd4, 3'd5};
        logic [31:0] as  [9] = '{32'd7, 32'd5, 32'hFFFF_FFFF, 32'hF0F0, 32'hF0F0, 32'd0,
                                 32'hFFFF_FFFF, 32'd0, 32'd0};
        logic [31:0] bs  [9] = '{32'd5, 32'd5, 32'd1, 32'hFF00, 32'hFF00, 32'd0, 32'd1,
                                 32'd1, 32'h8000_0000};
        logic [4:0]  ss  [9] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd31, 5'd4};
        logic [31:0] ex  [9] = '{32'd12, 32'd0, 32'd0, 32'hF000, 32'hFFF0, 32'hFFFF_FFFF,
                                 32'd1, 32'h8000_0000, 32'h0800_0000};
        for (int i = 0; i < 9; i++) begin
            aluOp = ops[i]; aluA = as[i]; aluB = bs[i]; shamt = ss[i];
            #1;
            nCompared++;
            if (aluOut !== ex[i] || zeroFlag !== (ex[i] == 32'd0)) begin
                nMismatched++;
                $display("FAIL alu_dir%0d op%0d: got %h z%b want %h z%b", i, aluOp,
                         aluOut, zeroFlag, ex[i], ex[i] == 32'd0);
            end
        end
    endtask

    task automatic test_bypass();
        regWrite = 1'b1; writeReg = 5'd9; writeData = 32'd123;
        readReg1 = 5'd9; readReg2 = 5'd9;
        #1;
`ifdef ALU_REGFILE_BYPASS_EN
        nCompared++;
        if (readData1 !== 32'd123 || readData2 !== 32'd123) begin
            nMismatched++;
            $display("FAIL bypass_pre: got %h/%h want %h", readData1, readData2, 32'd123);
        end
`else
        nCompared++;
        if (readData1 !== 32'd0 || readData2 !== 32'd0) begin
            nMismatched++;
            $display("FAIL bypass_pre: got %h/%h want %h", readData1, readData2, 32'd0);
        end
`endif
        tick();
        regWrite = 1'b0;
        #1;
        nCompared++;
        if (readData1 !== 32'd123 || readData2 !== 32'd123) begin
            nMismatched++;
            $display("FAIL bypass_post: got %h/%h want %h", readData1, readData2, 32'd123);
        end
    endtask

    task automatic test_random();
        logic [31:0] e1, e2, ea;
        for (int n = 0; n < 400; n++) begin
            reset     = ($urandom_range(0, 49) == 0);
            regWrite  = $urandom_range(0, 1) == 1;
            writeReg  = 5'($urandom_range(0, 31));
            writeData = $urandom;
            readReg1  = ($urandom_range(0, 3) == 0) ? writeReg : 5'($urandom_range(0, 31));
            readReg2  = ($urandom_range(0, 3) == 0) ? writeReg : 5'($urandom_range(0, 31));
            aluOp     = 3'($urandom_range(0, 7));
            aluA      = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            aluB      = ($urandom_range(0, 7) == 0) ? aluA : $urandom;
            shamt     = 5'($urandom_range(0, 31));
            #1;
            e1 = expRead(readReg1);
            e2 = expRead(readReg2);
            ea = expAlu(aluOp, aluA, aluB, shamt);
            nCompared++;
            if (readData1 !== e1 || readData2 !== e2) begin
                nMismatched++;
                $display("FAIL rand_read%0d r%0d/r%0d: got %h/%h want %h/%h", n,
                         readReg1, readReg2, readData1, readData2, e1, e2);
            end
            nCompared++;
            if (aluOut !== ea || zeroFlag !== (ea == 32'd0)) begin
                nMismatched++;
                $display("FAIL rand_alu%0d op%0d a%h b%h s%0d: got %h z%b want %h", n,
                         aluOp, aluA, aluB, shamt, aluOut, zeroFlag, ea);
            end
            tick();
        end
        reset = 1'b0; regWrite = 1'b0;
    endtask

    initial begin
        reset = 1'b1; regWrite = 1'b0; writeReg = '0; writeData = '0;
        readReg1 = '0; readReg2 = '0; aluA = '0; aluB = '0; aluOp = '0; shamt = '0;
        for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
        test_reset();
        test_write_read();
        test_alu_directed();
        test_bypass();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
